// File: rtl/mcu_timer_if.sv
// mcu_timer_if: control, SFR-write and status signals of the 8051-style timer.
//   master : the core side; drives run/gate/mode controls, pins, SFR writes, tf_clr
//   slave  : the timer; drives tl/th count bytes, sticky tf and one-cycle ovf
interface mcu_timer_if;
  logic       tr;
  logic       gate;
  logic       int_pin;
  logic       ct;
  logic [1:0] mode;
  logic       t_pin;
  logic       wr_en;
  logic       wr_sel;
  logic [7:0] wr_data;
  logic       tf_clr;
  logic [7:0] tl;
  logic [7:0] th;
  logic       tf;
  logic       ovf;

  modport master (
    output tr, gate, int_pin, ct, mode, t_pin, wr_en, wr_sel, wr_data, tf_clr,
    input  tl, th, tf, ovf
  );

  modport slave (
    input  tr, gate, int_pin, ct, mode, t_pin, wr_en, wr_sel, wr_data, tf_clr,
    output tl, th, tf, ovf
  );
endinterface

// File: rtl/mcu_timer.sv
// mcu_timer: 8051-style timer/counter.
// A free-running prescaler divides clk_in down to the machine-cycle tick. Each
// tick the count advances either unconditionally (timer) or on a 1->0 change of
// t_pin seen across two consecutive ticks (counter), subject to tr/gate/int_pin.
// Modes: 0 = 13-bit, 1 = 16-bit, 2 = 8-bit auto-reload from th, 3 = hold.
// Ports:
//   clk_in : divided clock from the clock divider
//   rst_n  : asynchronous active-low reset
//   bus    : mcu_timer_if.slave (controls, SFR write, tl/th/tf/ovf)
module mcu_timer #(
  parameter int PRESCALE = 12  // input clocks per machine cycle, 2..15
) (
  input  logic        clk_in,
  input  logic        rst_n,
  mcu_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    MODE_13   = 2'd0,
    MODE_16   = 2'd1,
    MODE_8AR  = 2'd2,
    MODE_HOLD = 2'd3
  } mode_e;

  localparam logic [3:0] PRESC_MAX = 4'(PRESCALE - 1);

  logic [3:0]  presc;
  logic        t_q;
  logic [7:0]  tl_q;
  logic [7:0]  th_q;
  logic        tf_q;
  logic        ovf_q;

  mode_e       mode;
  logic        tick;
  logic        run;
  logic        edge_ok;
  logic        inc;
  logic        at_max;
  logic        ovf_now;
  logic [12:0] cnt13_nxt;
  logic [15:0] cnt16_nxt;

  assign mode = mode_e'(bus.mode);

  // NOTE: every signal gets a value before the case below, so no latch is inferred.
  always_comb begin
    tick      = (presc == PRESC_MAX);
    run       = bus.tr & (~bus.gate | bus.int_pin);
    // Counter mode needs the pin high at the previous tick and low at this one.
    edge_ok   = bus.ct ? (t_q & ~bus.t_pin) : 1'b1;
    inc       = tick & run & edge_ok & (mode != MODE_HOLD);
    cnt13_nxt = {th_q, tl_q[4:0]} + 13'd1;
    cnt16_nxt = {th_q, tl_q} + 16'd1;
    at_max    = 1'b0;
    case (mode)
      MODE_13:  at_max = ({th_q, tl_q[4:0]} == 13'h1FFF);
      MODE_16:  at_max = ({th_q, tl_q} == 16'hFFFF);
      MODE_8AR: at_max = (tl_q == 8'hFF);
      default:  at_max = 1'b0;
    endcase
    // An SFR write owns the count for its cycle, so it also suppresses overflow.
    ovf_now   = inc & at_max & ~bus.wr_en;
  end

  // Prescaler and pin sampler run regardless of tr and mode.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      presc <= 4'd0;
      t_q   <= 1'b1;
    end else begin
      presc <= tick ? 4'd0 : presc + 4'd1;
      if (tick) t_q <= bus.t_pin;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      tl_q  <= 8'h00;
      th_q  <= 8'h00;
      tf_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_now;
      // Set beats clear when both land in the same cycle.
      tf_q  <= ovf_now | (tf_q & ~bus.tf_clr);
      if (bus.wr_en) begin
        if (bus.wr_sel) th_q <= bus.wr_data;
        else            tl_q <= bus.wr_data;
      end else if (inc) begin
        case (mode)
          MODE_13: begin
            // tl[7:5] are not part of the 13-bit count and keep their value.
            th_q <= cnt13_nxt[12:5];
            tl_q <= {tl_q[7:5], cnt13_nxt[4:0]};
          end
          MODE_16:  {th_q, tl_q} <= cnt16_nxt;
          MODE_8AR: tl_q <= at_max ? th_q : tl_q + 8'd1;
          default:  ;
        endcase
      end
    end
  end

  assign bus.tl  = tl_q;
  assign bus.th  = th_q;
  assign bus.tf  = tf_q;
  assign bus.ovf = ovf_q;

endmodule

// File: tb/tb_mcu_timer.sv
// Self-checking bench for mcu_timer. A cycle-level arithmetic model tracks
// the expected tl/th/tf/ovf and is compared with the DUT on every falling edge;
// directed literal checks pin the model at the interesting points.
module tb_mcu_timer;
  localparam int PRESCALE = 12;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  mcu_timer_if bus ();

  mcu_timer #(.PRESCALE(PRESCALE)) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_cyc;     // clock cycles since reset release
  int m_tl, m_th;
  bit m_tf, m_ovf, m_tq, m_ticked;

  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc <= 0; m_tl <= 0; m_th <= 0; m_tf <= 0; m_ovf <= 0; m_tq <= 1; m_ticked <= 0;
    end else begin : model_step
      automatic bit tk      = (m_cyc % PRESCALE) == PRESCALE - 1;
      automatic bit running = bus.tr && (!bus.gate || bus.int_pin);
      automatic bit pulse   = bus.ct ? (m_tq && !bus.t_pin) : 1'b1;
      automatic bit adv     = tk && running && pulse && (bus.mode != 2'd3);
      automatic bit wrap    = 1'b0;
      automatic int v       = 0;
      automatic int ntl     = m_tl;
      automatic int nth     = m_th;
      if (bus.wr_en) begin
        if (bus.wr_sel) nth = int'(bus.wr_data);
        else            ntl = int'(bus.wr_data);
      end else if (adv) begin
        if (bus.mode == 2'd0) begin
          v    = m_th * 32 + m_tl % 32 + 1;
          wrap = (v == 8192);
          v    = v % 8192;
          nth  = v / 32;
          ntl  = (m_tl / 32) * 32 + v % 32;
        end else if (bus.mode == 2'd1) begin
          v    = m_th * 256 + m_tl + 1;
          wrap = (v == 65536);
          v    = v % 65536;
          nth  = v / 256;
          ntl  = v % 256;
        end else begin
          wrap = (m_tl == 255);
          ntl  = wrap ? m_th : m_tl + 1;
        end
      end
      m_tl     <= ntl;
      m_th     <= nth;
      m_ovf    <= wrap;
      m_tf     <= wrap ? 1'b1 : (bus.tf_clr ? 1'b0 : m_tf);
      if (tk) m_tq <= bus.t_pin;
      m_cyc    <= m_cyc + 1;
      m_ticked <= tk;
    end
  end

  always @(negedge clk_in) begin
    if (rst_n && cmp_en) begin
      check("cmp_tl",  int'(bus.tl),  m_tl);
      check("cmp_th",  int'(bus.th),  m_th);
      check("cmp_tf",  int'(bus.tf),  int'(m_tf));
      check("cmp_ovf", int'(bus.ovf), int'(m_ovf));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic run_ticks(input int n);
    int seen  = 0;
    int guard = 0;
    while (seen < n && guard < 1000) begin
      step();
      guard++;
      if (m_ticked) seen++;
    end
    if (seen < n) check("tick_timeout", seen, n);
  endtask

  // Advance until the current cycle is a tick cycle.
  task automatic wait_tick_cycle();
    int guard = 0;
    while ((m_cyc % PRESCALE) != PRESCALE - 1 && guard < 100) begin
      step();
      guard++;
    end
    if (guard >= 100) check("tick_cycle_timeout", guard, 0);
  endtask

  task automatic sfr_write(input bit sel, input logic [7:0] data);
    bus.wr_en = 1'b1; bus.wr_sel = sel; bus.wr_data = data;
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic clear_tf();
    bus.tf_clr = 1'b1;
    step();
    bus.tf_clr = 1'b0;
  endtask

  task automatic pin_periods(input int n);
    for (int i = 0; i < n; i++) begin
      bus.t_pin = 1'b0; run_ticks(3);
      bus.t_pin = 1'b1; run_ticks(3);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.tr = 1'b1; bus.gate = 1'b0; bus.int_pin = 1'b0; bus.ct = 1'b0;
    bus.mode = 2'd1; bus.t_pin = 1'b1; bus.wr_en = 1'b0; bus.wr_sel = 1'b0;
    bus.wr_data = 8'h00; bus.tf_clr = 1'b0;

    #2;
    check("rst_tl",  int'(bus.tl),  0);
    check("rst_tf",  int'(bus.tf),  0);
    #20 rst_n = 1'b1;
    cmp_en = 1'b1;

    // Timer mode 1: first increment visible at cycle 12, then every 12 clocks.
    repeat (11) step();
    check("t1_cycle11_tl", int'(bus.tl), 0);
    step();
    check("t1_cycle12_tl", int'(bus.tl), 1);
    repeat (12) step();
    check("t1_cycle24_tl", int'(bus.tl), 2);

    // Mode 1 overflow from 0xFFFE.
    bus.tr = 1'b0;
    sfr_write(1'b1, 8'hFF);
    sfr_write(1'b0, 8'hFE);
    bus.tr = 1'b1;
    run_ticks(1);
    check("m1_ffff", int'({bus.th, bus.tl}), 16'hFFFF);
    run_ticks(1);
    check("m1_wrap",     int'({bus.th, bus.tl}), 0);
    check("m1_ovf_high", int'(bus.ovf), 1);
    check("m1_tf_set",   int'(bus.tf),  1);
    step();
    check("m1_ovf_low",  int'(bus.ovf), 0);
    check("m1_tf_stick", int'(bus.tf),  1);
    clear_tf();
    check("m1_tf_clr",   int'(bus.tf),  0);

    // Mode 2 auto-reload.
    bus.tr = 1'b0; bus.mode = 2'd2;
    sfr_write(1'b1, 8'hF0);
    sfr_write(1'b0, 8'hFE);
    bus.tr = 1'b1;
    run_ticks(2);
    check("m2_reload_tl", int'(bus.tl), 8'hF0);
    check("m2_th_keep",   int'(bus.th), 8'hF0);
    check("m2_tf",        int'(bus.tf), 1);
    clear_tf();
    run_ticks(16);
    check("m2_reload2_tl", int'(bus.tl), 8'hF0);
    check("m2_tf2",        int'(bus.tf), 1);

    // Mode 0: 13-bit wrap keeps tl[7:5].
    bus.tr = 1'b0;
    clear_tf();
    bus.mode = 2'd0;
    sfr_write(1'b1, 8'hFF);
    sfr_write(1'b0, 8'hBF);
    bus.tr = 1'b1;
    run_ticks(1);
    check("m0_th", int'(bus.th), 8'h00);
    check("m0_tl", int'(bus.tl), 8'hA0);
    check("m0_tf", int'(bus.tf), 1);

    // Counter mode: four pin periods, then gating, then resume.
    bus.tr = 1'b0; bus.mode = 2'd1; bus.ct = 1'b1; bus.t_pin = 1'b1;
    sfr_write(1'b1, 8'h00);
    sfr_write(1'b0, 8'h00);
    clear_tf();
    bus.tr = 1'b1;
    run_ticks(2);
    pin_periods(4);
    check("ctr_count4", int'(bus.tl), 4);
    bus.gate = 1'b1; bus.int_pin = 1'b0;
    pin_periods(2);
    check("ctr_gated", int'(bus.tl), 4);
    bus.int_pin = 1'b1;
    pin_periods(1);
    check("ctr_resume", int'(bus.tl), 5);
    bus.gate = 1'b0; bus.ct = 1'b0;

    // Mode 3 holds.
    bus.mode = 2'd3;
    run_ticks(3);
    check("m3_hold", int'(bus.tl), 5);
    bus.mode = 2'd1;

    // Write on the tick cycle at 0xFFFF: write wins, no overflow.
    bus.tr = 1'b0;
    sfr_write(1'b1, 8'hFF);
    sfr_write(1'b0, 8'hFF);
    clear_tf();
    wait_tick_cycle();
    bus.tr = 1'b1;
    bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_data = 8'h55;
    step();
    bus.wr_en = 1'b0; bus.tr = 1'b0;
    check("col_wr_tl",  int'(bus.tl),  8'h55);
    check("col_wr_th",  int'(bus.th),  8'hFF);
    check("col_wr_ovf", int'(bus.ovf), 0);
    check("col_wr_tf",  int'(bus.tf),  0);

    // Overflow and tf_clr in the same cycle: set wins.
    sfr_write(1'b0, 8'hFF);
    wait_tick_cycle();
    bus.tr = 1'b1; bus.tf_clr = 1'b1;
    step();
    bus.tf_clr = 1'b0; bus.tr = 1'b0;
    check("col_clr_tf",  int'(bus.tf),  1);
    check("col_clr_ovf", int'(bus.ovf), 1);
    check("col_clr_cnt", int'({bus.th, bus.tl}), 0);

    // Asynchronous reset mid-count, then the prescaler phase restarts.
    bus.tr = 1'b1;
    run_ticks(3);
    check("pre_rst_tl", int'(bus.tl), 3);
    #3 rst_n = 1'b0;
    #1;
    check("arst_tl",  int'(bus.tl),  0);
    check("arst_th",  int'(bus.th),  0);
    check("arst_tf",  int'(bus.tf),  0);
    check("arst_ovf", int'(bus.ovf), 0);
    #1 rst_n = 1'b1;
    repeat (11) step();
    check("post_rst_c11", int'(bus.tl), 0);
    step();
    check("post_rst_c12", int'(bus.tl), 1);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
